// File: rtl/apb_reg_subsystem.sv
// APB master bridge and four-register identity slave sharing one internal APB bus.
// The master issues host requests back to back; every bus signal is also an output.
module apb_reg_subsystem #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PWRITE_MASTER,
   input  logic [ADDR_W-1:0] PADDR_MASTER,
   input  logic [DATA_W-1:0] PWDATA_MASTER,
   output logic [DATA_W-1:0] PRDATA_MASTER,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY
);

   // state     | meaning
   // ST_IDLE   | after reset, bus idle for one cycle
   // ST_SETUP  | PSEL=1, PENABLE=0, request latched on entry
   // ST_ACCESS | PSEL=1, PENABLE=1, completes when PREADY=1
   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

   state_t state_q, state_d;
   logic   latch_req;
   logic   addr_valid;
   logic [DATA_W-1:0] id_reg [4];  // number_in_group, date, surname, name

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      latch_req = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d   = ST_SETUP;
            latch_req = 1'b1;
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (PREADY) begin
               state_d   = ST_SETUP;
               latch_req = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign PSEL    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign PENABLE = (state_q == ST_ACCESS);

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         PWRITE        <= 1'b0;
         PADDR         <= '0;
         PWDATA        <= '0;
         PRDATA_MASTER <= '0;
      end else begin
         // read data is captured from the transfer that is completing, before the new latch
         if (state_q == ST_ACCESS && PREADY && !PWRITE) PRDATA_MASTER <= PRDATA;
         if (latch_req) begin
            PWRITE <= PWRITE_MASTER;
            PADDR  <= PADDR_MASTER;
            PWDATA <= PWDATA_MASTER;
         end
      end
   end

   assign addr_valid = (PADDR[ADDR_W-1:4] == '0) && (PADDR[1:0] == 2'b00);
   assign PREADY     = PSEL & PENABLE;

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         for (int i = 0; i < 4; i++) id_reg[i] <= '0;
      end else if (PSEL && PENABLE && PWRITE && addr_valid) begin
         id_reg[PADDR[3:2]] <= PWDATA;
      end
   end

   assign PRDATA = (PSEL && !PWRITE && addr_valid) ? id_reg[PADDR[3:2]] : '0;

endmodule

// File: tb/tb_apb_reg_subsystem.sv
// Bench for apb_reg_subsystem: transfer-level model, per-cycle compare, directed and random stimulus.
module tb_apb_reg_subsystem;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        PWRITE_MASTER;
   logic [31:0] PADDR_MASTER;
   logic [31:0] PWDATA_MASTER;
   logic [31:0] PRDATA_MASTER;
   logic        PSEL, PENABLE, PWRITE, PREADY;
   logic [31:0] PADDR, PWDATA, PRDATA;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   apb_reg_subsystem #(.ADDR_W(32), .DATA_W(32)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .PWRITE_MASTER(PWRITE_MASTER), .PADDR_MASTER(PADDR_MASTER),
      .PWDATA_MASTER(PWDATA_MASTER), .PRDATA_MASTER(PRDATA_MASTER),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   // Model: after reset release, odd edge n samples a request (SETUP), even edges enter ACCESS,
   // and each odd edge from the third on completes the previously sampled transfer.
   int          m_e = 0;
   bit          m_wr = 1'b0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_rdm = '0;
   logic [31:0] mem [4] = '{default: '0};

   function automatic bit valid_addr(input logic [31:0] a);
      return (a[31:4] == 28'd0) && (a[1:0] == 2'b00);
   endfunction

   always @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         m_e = 0; m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_rdm = '0;
         for (int i = 0; i < 4; i++) mem[i] = '0;
      end else begin
         m_e++;
         if (m_e % 2 == 1) begin
            if (m_e >= 3) begin
               if (m_wr) begin
                  if (valid_addr(m_addr)) mem[m_addr[3:2]] = m_wdata;
               end else begin
                  m_rdm = valid_addr(m_addr) ? mem[m_addr[3:2]] : 32'd0;
               end
            end
            m_wr    = PWRITE_MASTER;
            m_addr  = PADDR_MASTER;
            m_wdata = PWDATA_MASTER;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge PCLK) begin
      if (chk_en) begin
         #1;
         begin
            bit          e_psel, e_pen, e_rdv;
            logic [31:0] e_prdata;
            e_psel   = (m_e > 0);
            e_pen    = (m_e > 0) && (m_e % 2 == 0);
            e_rdv    = e_psel && !m_wr && valid_addr(m_addr);
            e_prdata = e_rdv ? mem[m_addr[3:2]] : 32'd0;
            check("psel",    {31'd0, PSEL},    {31'd0, e_psel});
            check("penable", {31'd0, PENABLE}, {31'd0, e_pen});
            check("pready",  {31'd0, PREADY},  {31'd0, e_psel & e_pen});
            check("pwrite",  {31'd0, PWRITE},  {31'd0, m_wr});
            check("paddr",   PADDR,   m_addr);
            check("pwdata",  PWDATA,  m_wdata);
            check("prdata",  PRDATA,  e_prdata);
            check("prdata_master", PRDATA_MASTER, m_rdm);
            if (PENABLE && !PSEL) check("penable_without_psel", 32'd1, 32'd0);
         end
      end
   end

   // Present one request and hold it for the two cycles of its transfer; returns in ACCESS.
   task automatic req(input bit wr, input logic [31:0] addr, input logic [31:0] data);
      PWRITE_MASTER = wr;
      PADDR_MASTER  = addr;
      PWDATA_MASTER = data;
      @(posedge PCLK);
      @(posedge PCLK);
      @(negedge PCLK);
   endtask

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      check(name, act, exp);
   endtask

   initial begin
      PRESET = 1'b0;
      PWRITE_MASTER = 1'b0;
      PADDR_MASTER  = '0;
      PWDATA_MASTER = '0;
      repeat (3) @(negedge PCLK);
      chk_en = 1'b1;
      #2;
      lit("rst_psel",    {31'd0, PSEL},    32'd0);
      lit("rst_penable", {31'd0, PENABLE}, 32'd0);
      lit("rst_paddr",   PADDR,            32'd0);
      lit("rst_prdm",    PRDATA_MASTER,    32'd0);

      @(negedge PCLK);
      PRESET = 1'b1;
      PWRITE_MASTER = 1'b1; PADDR_MASTER = 32'h0; PWDATA_MASTER = 32'd23;
      @(posedge PCLK); #1;
      lit("first_setup_psel",    {31'd0, PSEL},    32'd1);
      lit("first_setup_penable", {31'd0, PENABLE}, 32'd0);
      @(posedge PCLK); @(negedge PCLK); #2;
      lit("access_pready", {31'd0, PREADY}, 32'd1);
      lit("access_pwdata", PWDATA, 32'd23);

      req(1'b1, 32'h4, 32'h20122023);
      req(1'b1, 32'h8, 32'h98A0A1A0);
      req(1'b1, 32'hC, 32'h85AAA0E2);
      req(1'b1, 32'h10, 32'hFFFFFFFF);
      req(1'b1, 32'h6,  32'hFFFFFFFF);
      req(1'b0, 32'h0, 32'h0);
      req(1'b0, 32'h4, 32'h0);  #2; lit("rd_0x0", PRDATA_MASTER, 32'd23);
      req(1'b0, 32'h8, 32'h0);  #2; lit("rd_0x4", PRDATA_MASTER, 32'h20122023);
      req(1'b0, 32'hC, 32'h0);  #2; lit("rd_0x8", PRDATA_MASTER, 32'h98A0A1A0);
      req(1'b0, 32'h10, 32'h0); #2; lit("rd_0xC", PRDATA_MASTER, 32'h85AAA0E2);
      lit("inv_rd_pready", {31'd0, PREADY}, 32'd1);
      req(1'b1, 32'h0, 32'h5);  #2; lit("rd_0x10", PRDATA_MASTER, 32'd0);
      req(1'b1, 32'h8, 32'h77); #2; lit("wr_holds_prdm", PRDATA_MASTER, 32'd0);

      // reset during the ACCESS cycle of a write to 0x4
      PWRITE_MASTER = 1'b1; PADDR_MASTER = 32'h4; PWDATA_MASTER = 32'hDEADBEEF;
      @(posedge PCLK); @(posedge PCLK); @(negedge PCLK);
      PRESET = 1'b0;
      #2;
      lit("midrst_psel",  {31'd0, PSEL}, 32'd0);
      lit("midrst_paddr", PADDR, 32'd0);
      @(negedge PCLK);
      PRESET = 1'b1;
      req(1'b0, 32'h4, 32'h0);
      req(1'b0, 32'h0, 32'h0); #2; lit("midrst_reg_0x4", PRDATA_MASTER, 32'd0);

      // random phase: inputs change every cycle, occasional resets
      for (int i = 0; i < 800; i++) begin
         int sel;
         sel = $urandom_range(0, 9);
         PWRITE_MASTER = $urandom_range(0, 1);
         case (sel)
            0, 1, 2, 3, 4, 5: PADDR_MASTER = {28'd0, 2'($urandom_range(0, 3)), 2'b00};
            6: PADDR_MASTER = 32'h10;
            7: PADDR_MASTER = {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(1, 3))};
            default: PADDR_MASTER = $urandom;
         endcase
         PWDATA_MASTER = $urandom;
         if ($urandom_range(0, 59) == 0) PRESET = 1'b0;
         else                            PRESET = 1'b1;
         @(negedge PCLK);
      end
      PRESET = 1'b1;
      repeat (2) @(negedge PCLK);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
